// File: rtl/line_read_scheduler.sv
`timescale 1ns/1ps
// Read-side scheduler for the low-res frame buffer: owns the raster counters,
// generates syncs and issues one Next_Line request per displayed line.
module line_read_scheduler #(
    parameter int unsigned H_ACTIVE = 320,
    parameter int unsigned H_FRONT  = 8,
    parameter int unsigned H_SYNC   = 48,
    parameter int unsigned H_BACK   = 24,
    parameter int unsigned V_ACTIVE = 240,
    parameter int unsigned V_FRONT  = 3,
    parameter int unsigned V_SYNC   = 3,
    parameter int unsigned V_BACK   = 16
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       Frame_Ready,
    output logic       Next_Line,
    output logic [7:0] Row_Select,
    output logic       Pixel_Active,
    output logic       HSync,
    output logic       VSync,
    output logic       Frame_Start
);

    localparam int unsigned H_W      = 9;
    localparam int unsigned V_W      = 9;
    localparam int unsigned ROW_W    = 8;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_ACTIVE + H_FRONT;
    localparam int unsigned HS_END   = H_ACTIVE + H_FRONT + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FRONT;
    localparam int unsigned VS_END   = V_ACTIVE + V_FRONT + V_SYNC;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARM    = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [H_W-1:0] h_cnt;
    logic [V_W-1:0] v_cnt;
    logic [V_W-1:0] nv;
    logic           h_last;
    logic           frame_end;
    logic           line_req;
    logic           in_hsync;
    logic           in_vsync;
    logic           in_pixel;

    // Raster position decode shared by the counters, FSM and outputs
    always_comb begin
        h_last    = (h_cnt == H_W'(H_TOTAL - 1));
        frame_end = h_last && (v_cnt == V_W'(V_TOTAL - 1));
        nv        = (v_cnt == V_W'(V_TOTAL - 1)) ? '0 : v_cnt + V_W'(1);
        in_hsync  = (h_cnt >= H_W'(HS_START)) && (h_cnt < H_W'(HS_END));
        in_vsync  = (v_cnt >= V_W'(VS_START)) && (v_cnt < V_W'(VS_END));
        in_pixel  = (state == ST_ACTIVE) && (v_cnt < V_W'(V_ACTIVE)) &&
                    (h_cnt >= H_W'(1)) && (h_cnt <= H_W'(H_ACTIVE));
        // Request only lines that will actually be shown, including row 0 of
        // the first displayed frame; a frame about to be dropped gets none.
        line_req  = h_last && (nv < V_W'(V_ACTIVE)) && (state_nxt == ST_ACTIVE);
    end

    // Free-running horizontal/vertical raster counters
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= nv;
        end else begin
            h_cnt <= h_cnt + H_W'(1);
        end
    end

    // Display gating FSM state register
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: display only ever starts or stops on a frame boundary
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (Frame_Ready) begin
                    state_nxt = ST_ARM;
                end
            end
            ST_ARM: begin
                if (!Frame_Ready) begin
                    state_nxt = ST_IDLE;
                end else if (frame_end) begin
                    state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (frame_end && !Frame_Ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Registered outputs, one cycle behind the counter values they decode
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            Next_Line    <= 1'b0;
            Row_Select   <= '0;
            Pixel_Active <= 1'b0;
            HSync        <= 1'b1;
            VSync        <= 1'b1;
            Frame_Start  <= 1'b0;
        end else begin
            Next_Line    <= line_req;
            if (line_req) begin
                Row_Select <= ROW_W'(nv);
            end
            Pixel_Active <= in_pixel;
            HSync        <= ~in_hsync;
            VSync        <= ~in_vsync;
            Frame_Start  <= (state == ST_ACTIVE) && (h_cnt == '0) && (v_cnt == '0);
        end
    end

endmodule

// File: tb/tb_line_read_scheduler.sv
`timescale 1ns/1ps
// Self-checking bench for line_read_scheduler using a reduced raster geometry.
module tb_line_read_scheduler;

    localparam int HA  = 20;
    localparam int HF  = 2;
    localparam int HSW = 4;
    localparam int HB  = 4;
    localparam int VA  = 12;
    localparam int VF  = 1;
    localparam int VSW = 2;
    localparam int VB  = 3;
    localparam int HT  = HA + HF + HSW + HB;
    localparam int VT  = VA + VF + VSW + VB;
    localparam int FT  = HT * VT;

    logic       CLK;
    logic       reset;
    logic       Frame_Ready;
    logic       Next_Line;
    logic [7:0] Row_Select;
    logic       Pixel_Active;
    logic       HSync;
    logic       VSync;
    logic       Frame_Start;

    line_read_scheduler #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB)
    ) dut (
        .CLK         (CLK),
        .reset       (reset),
        .Frame_Ready (Frame_Ready),
        .Next_Line   (Next_Line),
        .Row_Select  (Row_Select),
        .Pixel_Active(Pixel_Active),
        .HSync       (HSync),
        .VSync       (VSync),
        .Frame_Start (Frame_Start)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int k     = 0;
    int nl_seen = 0;
    int pa_cnt  = 0;
    int rows_q[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: raster position derived from elapsed cycles since reset.
    // mode: 0 = blanked, 1 = waiting for a frame boundary, 2 = showing frames.
    typedef struct {
        int t;
        int mode;
        bit nl;
        int row;
        bit pa;
        bit hs;
        bit vs;
        bit fs;
    } mdl_t;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.t = 0; m.mode = 0; m.nl = 0; m.row = 0;
        m.pa = 0; m.hs = 1; m.vs = 1; m.fs = 0;
        return m;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t m, input logic fr);
        mdl_t n = m;
        int h = m.t % HT;
        int v = (m.t / HT) % VT;
        int nv = (v + 1) % VT;
        bit boundary = (h == HT - 1) && (v == VT - 1);
        if (m.mode == 0) n.mode = fr ? 1 : 0;
        else if (m.mode == 1) n.mode = !fr ? 0 : (boundary ? 2 : 1);
        else n.mode = (boundary && !fr) ? 0 : 2;
        n.nl = (h == HT - 1) && (nv < VA) && (n.mode == 2);
        if (n.nl) n.row = nv;
        n.pa = (m.mode == 2) && (v < VA) && (h >= 1) && (h <= HA);
        n.hs = !((h >= HA + HF) && (h < HA + HF + HSW));
        n.vs = !((v >= VA + VF) && (v < VA + VF + VSW));
        n.fs = (m.mode == 2) && (h == 0) && (v == 0);
        n.t  = m.t + 1;
        return n;
    endfunction

    mdl_t mdl;

    // Advance the model alongside the DUT (inputs never change on posedge)
    always @(posedge CLK or negedge reset) begin
        if (!reset) mdl <= mdl_reset();
        else        mdl <= mdl_step(mdl, Frame_Ready);
    end

    // Cycle-by-cycle comparison against the model plus event bookkeeping
    always @(negedge CLK) begin
        chk("m_next_line", int'(Next_Line), int'(mdl.nl));
        chk("m_row_select", int'(Row_Select), mdl.row);
        chk("m_pixel_active", int'(Pixel_Active), int'(mdl.pa));
        chk("m_hsync", int'(HSync), int'(mdl.hs));
        chk("m_vsync", int'(VSync), int'(mdl.vs));
        chk("m_frame_start", int'(Frame_Start), int'(mdl.fs));
        if (Next_Line) begin
            nl_seen++;
            rows_q.push_back(int'(Row_Select));
        end
        if (Pixel_Active) pa_cnt++;
    end

    // Directed vectors: f/h/v = counter position (since release) at which the
    // outputs are observed; they reflect the previous counter position.
    typedef struct {
        int f; int h; int v; bit fr;
        bit nl; int row; bit pa; bit hs; bit vs; bit fs;
    } vec_t;

    vec_t tbl[$];

    task automatic goto_k(input int target);
        while (k < target) begin
            @(posedge CLK);
            k++;
        end
        @(negedge CLK);
    endtask

    task automatic run_vecs(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            Frame_Ready = tbl[i].fr;
            goto_k(tbl[i].f * FT + tbl[i].v * HT + tbl[i].h);
            chk({tag, "_next_line"}, int'(Next_Line), int'(tbl[i].nl));
            chk({tag, "_row_select"}, int'(Row_Select), tbl[i].row);
            chk({tag, "_pixel_active"}, int'(Pixel_Active), int'(tbl[i].pa));
            chk({tag, "_hsync"}, int'(HSync), int'(tbl[i].hs));
            chk({tag, "_vsync"}, int'(VSync), int'(tbl[i].vs));
            chk({tag, "_frame_start"}, int'(Frame_Start), int'(tbl[i].fs));
        end
    endtask

    task automatic release_reset();
        @(posedge CLK);
        #1 reset = 1'b1;
        k = 0;
    endtask

    initial begin
        int nl_before;
        // Frame_Ready high from the start: arm in frame 0, display frame 1
        tbl.push_back('{0,  5,  0, 1, 0,  0, 0, 1, 1, 0});
        tbl.push_back('{0, 23,  0, 1, 0,  0, 0, 0, 1, 0});
        tbl.push_back('{0, 27,  0, 1, 0,  0, 0, 1, 1, 0});
        tbl.push_back('{0,  0, 14, 1, 0,  0, 0, 1, 0, 0});
        tbl.push_back('{0,  0, 15, 1, 0,  0, 0, 1, 0, 0});
        tbl.push_back('{0,  0, 16, 1, 0,  0, 0, 1, 1, 0});
        tbl.push_back('{1,  0,  0, 1, 1,  0, 0, 1, 1, 0});
        tbl.push_back('{1,  1,  0, 1, 0,  0, 0, 1, 1, 1});
        tbl.push_back('{1,  2,  0, 1, 0,  0, 1, 1, 1, 0});
        tbl.push_back('{1, 21,  0, 1, 0,  0, 1, 1, 1, 0});
        tbl.push_back('{1, 22,  0, 1, 0,  0, 0, 1, 1, 0});
        tbl.push_back('{1,  0,  1, 1, 1,  1, 0, 1, 1, 0});
        // Frame_Ready drops mid-frame: the frame still completes
        tbl.push_back('{1,  0,  5, 0, 1,  5, 0, 1, 1, 0});
        tbl.push_back('{1,  2, 11, 0, 0, 11, 1, 1, 1, 0});
        tbl.push_back('{1,  0, 12, 0, 0, 11, 0, 1, 1, 0});
        tbl.push_back('{1,  2, 12, 0, 0, 11, 0, 1, 1, 0});
        tbl.push_back('{2,  0,  0, 0, 0, 11, 0, 1, 1, 0});
        tbl.push_back('{2,  1,  0, 0, 0, 11, 0, 1, 1, 0});
        tbl.push_back('{2,  2,  0, 0, 0, 11, 0, 1, 1, 0});
        tbl.push_back('{2,  0,  1, 0, 0, 11, 0, 1, 1, 0});
        // After a mid-line reset: counters restart, then a short ARM toggle
        tbl.push_back('{0, 23,  0, 0, 0,  0, 0, 0, 1, 0});
        tbl.push_back('{0, 27,  0, 0, 0,  0, 0, 1, 1, 0});
        tbl.push_back('{0,  0, 14, 0, 0,  0, 0, 1, 0, 0});
        tbl.push_back('{0,  0, 15, 1, 0,  0, 0, 1, 0, 0});
        tbl.push_back('{0,  0, 17, 0, 0,  0, 0, 1, 1, 0});
        tbl.push_back('{1,  0,  0, 0, 0,  0, 0, 1, 1, 0});
        tbl.push_back('{1,  1,  0, 0, 0,  0, 0, 1, 1, 0});
        tbl.push_back('{1,  2,  0, 0, 0,  0, 0, 1, 1, 0});
        tbl.push_back('{1,  0,  1, 0, 0,  0, 0, 1, 1, 0});

        reset = 1'b0;
        Frame_Ready = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_next_line", int'(Next_Line), 0);
        chk("rst_hsync", int'(HSync), 1);
        chk("rst_vsync", int'(VSync), 1);
        release_reset();
        run_vecs(0, 19);

        // Reach active display, then reset in the middle of a line
        Frame_Ready = 1'b1;
        goto_k(3 * FT + 6 * HT + 10);
        chk("pre_rst_pixel_active", int'(Pixel_Active), 1);
        chk("pre_rst_row_select", int'(Row_Select), 6);
        reset = 1'b0;
        #1;
        chk("midrst_next_line", int'(Next_Line), 0);
        chk("midrst_pixel_active", int'(Pixel_Active), 0);
        chk("midrst_hsync", int'(HSync), 1);
        chk("midrst_vsync", int'(VSync), 1);
        chk("midrst_row_select", int'(Row_Select), 0);
        chk("midrst_frame_start", int'(Frame_Start), 0);
        Frame_Ready = 1'b0;
        repeat (2) @(posedge CLK);
        nl_before = nl_seen;
        release_reset();
        run_vecs(20, 28);
        chk("arm_toggle_pulses", nl_seen - nl_before, 0);

        // Steady state: one full displayed frame
        Frame_Ready = 1'b1;
        goto_k(2 * FT - 20);
        rows_q.delete();
        pa_cnt = 0;
        goto_k(3 * FT - 20);
        chk("steady_pulse_count", rows_q.size(), VA);
        for (int i = 0; i < rows_q.size(); i++) begin
            chk($sformatf("steady_row%0d", i), rows_q[i], i);
        end
        chk("steady_pixel_count", pa_cnt, VA * HA);

        // Drop Frame_Ready at line 5 of the next frame
        goto_k(3 * FT + 5 * HT);
        Frame_Ready = 1'b0;
        goto_k(3 * FT + 5 * HT + 5);
        rows_q.delete();
        goto_k(5 * FT);
        chk("drop_pulse_count", rows_q.size(), VA - 6);
        for (int i = 0; i < rows_q.size(); i++) begin
            chk($sformatf("drop_row%0d", i), rows_q[i], i + 6);
        end

        // Random Frame_Ready activity and occasional reset pulses
        Frame_Ready = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            @(posedge CLK);
            #1;
            if ($urandom_range(0, 799) == 0) Frame_Ready = ~Frame_Ready;
            reset = ($urandom_range(0, 4999) == 0) ? 1'b0 : 1'b1;
        end
        #1 reset = 1'b1;
        repeat (4) @(posedge CLK);
        @(negedge CLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/line_read_scheduler.md
Name: line_read_scheduler

Overview:
- Sequences the read side of the SPI low-res frame buffer for the video output path.
- Owns the raster timing: a horizontal counter and a vertical counter.
- Issues one Next_Line pulse and a Row_Select index per displayed line, so the buffer streams 160 columns × 2 (column doubling) = 320 pixel clocks per line.
- Row_Select[7:1] selects one of 120 buffer rows, so each row is displayed twice (line doubling).
- Gates display on a frame-ready indication and always starts display on a frame boundary.

Parameters:
- H_ACTIVE, 320, active pixel clocks per line.
- H_FRONT, 8, horizontal front porch clocks.
- H_SYNC, 48, hsync pulse width in clocks.
- H_BACK, 24, horizontal back porch clocks (H_TOTAL = 400).
- V_ACTIVE, 240, active lines per frame.
- V_FRONT, 3, vertical front porch lines.
- V_SYNC, 3, vsync pulse width in lines.
- V_BACK, 16, vertical back porch lines (V_TOTAL = 262).

Ports:
- CLK  input  1  pixel/system clock; same clock that drives the buffer read side.
- reset  input  1  asynchronous, active-low reset.
- Frame_Ready  input  1  high when the buffer holds a complete frame (buffer Full).
- Next_Line  output  1  one-cycle pulse requesting the buffer to stream the next line.
- Row_Select  output  8  display line index 0..V_ACTIVE-1 for the line being requested.
- Pixel_Active  output  1  high while buffer Data_Frame is a valid displayed pixel.
- HSync  output  1  active-low horizontal sync.
- VSync  output  1  active-low vertical sync.
- Frame_Start  output  1  one-cycle pulse at h=0, v=0 while in ACTIVE.

Behaviour:
- Reset (reset=0, asynchronous):
  - h_cnt=0, v_cnt=0, state=IDLE.
  - Next_Line=0, Row_Select=0, Pixel_Active=0, HSync=1, VSync=1, Frame_Start=0.
- Counters (free-run in every state once reset=1):
  - h_cnt counts 0..H_TOTAL-1, then wraps to 0.
  - v_cnt increments on each h wrap and wraps V_TOTAL-1 -> 0.
  - Widths: h_cnt 9 bits, v_cnt 9 bits. All comparisons are unsigned.
- Sync generation (registered, all states):
  - HSync=0 for h_cnt in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC), i.e. h=328..375.
  - VSync=0 for v_cnt in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC), i.e. v=243..245.
  - Both outputs are registered with 1-cycle latency from the counter value.
- States:
  - IDLE: display blanked. If Frame_Ready=1 -> ARM.
  - ARM: wait for frame end (h=H_TOTAL-1, v=V_TOTAL-1). On that cycle -> ACTIVE. If Frame_Ready drops while in ARM -> IDLE.
  - ACTIVE: display running. At frame end: stay in ACTIVE if Frame_Ready=1, else -> IDLE. A Frame_Ready drop mid-frame has no effect until frame end; the current frame always completes.
- Next_Line:
  - Asserted for exactly one cycle when h_cnt=H_TOTAL-1 and the next line nv (v_cnt+1, wrapping to 0) is < V_ACTIVE.
  - Applies only in ACTIVE, or in ARM on the cycle it transitions to ACTIVE.
  - Row_Select <= nv[7:0] on that same edge and holds until the next Next_Line.
  - Exactly V_ACTIVE pulses per displayed frame; no pulses in blanking lines or in IDLE.
- Pixel_Active = 1 when state=ACTIVE, v_cnt<V_ACTIVE, and h_cnt in [1, H_ACTIVE].
  - The 1-cycle offset accounts for the buffer's registered read pointer after Next_Line.
- Frame_Start pulses at h=0, v=0 in ACTIVE.
- Simultaneous reset and any event: reset wins.
- Reset mid-line: all outputs return to their reset values immediately. The buffer's own reset realigns its read pointer.

Test Plan:
- Release reset with Frame_Ready=0, run 2 frames (209600 clocks) -> Next_Line never asserts, Pixel_Active=0, HSync low for 48 clocks every 400, VSync low for 1200 clocks per frame.
- Raise Frame_Ready at v=100 -> no Next_Line until frame end; first pulse at h=399, v=261 with Row_Select=0; Frame_Start at the next h=0, v=0.
- Steady state over one full frame -> exactly 240 Next_Line pulses, Row_Select sequence 0,1,...,239, Pixel_Active high for 320 clocks on each of v=0..239.
- Drop Frame_Ready at v=50 -> Next_Line continues through Row_Select=239, then state=IDLE and no pulses in the following frame.
- Assert reset at h=200, v=120 during ACTIVE -> same cycle: Next_Line=0, Pixel_Active=0, HSync=VSync=1, Row_Select=0; after release, counters restart from 0,0 in IDLE.
- Toggle Frame_Ready 1->0 while in ARM -> returns to IDLE with no Next_Line pulse emitted.
